// File: rtl/pipeline_mem_sync.sv
// Handshake between the pipeline step and the split I/D memories: holds requests until resp, then pulses advance.
// Optional stall counters are built only when MEM_SYNC_PERF_EN is defined.
module pipeline_mem_sync #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              need_data_read,
    input  logic              need_data_write,
    input  logic              stall_req,
    input  logic              inst_mem_resp,
    input  logic [DATA_W-1:0] inst_mem_rdata,
    input  logic              data_mem_resp,
    input  logic [DATA_W-1:0] data_mem_rdata,
    output logic              inst_mem_read,
    output logic              data_mem_read,
    output logic              data_mem_write,
    output logic              advance,
    output logic [DATA_W-1:0] inst_rdata_q,
    output logic [DATA_W-1:0] data_rdata_q,
    output logic [CNT_W-1:0]  inst_stall_cnt,
    output logic [CNT_W-1:0]  data_stall_cnt
);

    typedef enum logic [1:0] {REQ, HOLD, ADV} state_t;

    state_t state;
    logic   i_done;
    logic   d_done;
    logic   in_req;
    logic   data_req;
    logic   data_need;
    logic   i_hit;
    logic   d_hit;
    logic   step_done;

    // Outputs are gated by rst so nothing is requested while the memories are also in reset.
    assign in_req         = rst && (state == REQ);
    assign inst_mem_read  = in_req && !i_done;
    assign data_mem_write = in_req && need_data_write && !d_done;
    assign data_mem_read  = in_req && need_data_read && !need_data_write && !d_done;
    assign advance        = rst && (state == ADV);

    assign data_req  = data_mem_read || data_mem_write;
    assign data_need = need_data_read || need_data_write;
    assign i_hit     = inst_mem_read && inst_mem_resp;
    assign d_hit     = data_req && data_mem_resp;
    assign step_done = (i_done || i_hit) && (d_done || d_hit || !data_need);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= REQ;
            i_done       <= 1'b0;
            d_done       <= 1'b0;
            inst_rdata_q <= '0;
            data_rdata_q <= '0;
        end else begin
            case (state)
                REQ: begin
                    if (i_hit) begin
                        i_done       <= 1'b1;
                        inst_rdata_q <= inst_mem_rdata;
                    end
                    if (d_hit) begin
                        d_done <= 1'b1;
                        if (data_mem_read) begin
                            data_rdata_q <= data_mem_rdata;
                        end
                    end
                    if (step_done) begin
                        state <= stall_req ? HOLD : ADV;
                    end
                end
                HOLD: begin
                    if (!stall_req) begin
                        state <= ADV;
                    end
                end
                ADV: begin
                    i_done <= 1'b0;
                    d_done <= 1'b0;
                    state  <= REQ;
                end
                default: begin
                    state <= REQ;
                end
            endcase
        end
    end

`ifdef MEM_SYNC_PERF_EN
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == {CNT_W{1'b1}}) ? c : c + 1'b1;
    endfunction

    logic [CNT_W-1:0] inst_cnt;
    logic [CNT_W-1:0] data_cnt;

    // A request output being high already implies REQ state and rst released.
    always_ff @(posedge clk) begin
        if (!rst) begin
            inst_cnt <= '0;
            data_cnt <= '0;
        end else begin
            if (inst_mem_read && !inst_mem_resp) begin
                inst_cnt <= sat_inc(inst_cnt);
            end
            if (data_req && !data_mem_resp) begin
                data_cnt <= sat_inc(data_cnt);
            end
        end
    end

    assign inst_stall_cnt = inst_cnt;
    assign data_stall_cnt = data_cnt;
`else
    assign inst_stall_cnt = '0;
    assign data_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_mem_sync.sv
// Directed bench for pipeline_mem_sync; counter expectations follow MEM_SYNC_PERF_EN.
module tb_pipeline_mem_sync;

`ifdef MEM_SYNC_PERF_EN
    localparam int CNT_W = 4;
    localparam logic [3:0] EXP_I3  = 4'd3;
    localparam logic [3:0] EXP_D1  = 4'd1;
    localparam logic [3:0] EXP_I8  = 4'd8;
    localparam logic [3:0] EXP_SAT = 4'hF;
`else
    localparam int CNT_W = 32;
    localparam logic [31:0] EXP_I3  = 32'd0;
    localparam logic [31:0] EXP_D1  = 32'd0;
    localparam logic [31:0] EXP_I8  = 32'd0;
    localparam logic [31:0] EXP_SAT = 32'd0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             need_data_read;
    logic             need_data_write;
    logic             stall_req;
    logic             inst_mem_resp;
    logic [31:0]      inst_mem_rdata;
    logic             data_mem_resp;
    logic [31:0]      data_mem_rdata;
    logic             inst_mem_read;
    logic             data_mem_read;
    logic             data_mem_write;
    logic             advance;
    logic [31:0]      inst_rdata_q;
    logic [31:0]      data_rdata_q;
    logic [CNT_W-1:0] inst_stall_cnt;
    logic [CNT_W-1:0] data_stall_cnt;

    int n_assert = 0;
    int n_fail   = 0;

    pipeline_mem_sync #(.DATA_W(32), .CNT_W(CNT_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .need_data_read (need_data_read),
        .need_data_write(need_data_write),
        .stall_req      (stall_req),
        .inst_mem_resp  (inst_mem_resp),
        .inst_mem_rdata (inst_mem_rdata),
        .data_mem_resp  (data_mem_resp),
        .data_mem_rdata (data_mem_rdata),
        .inst_mem_read  (inst_mem_read),
        .data_mem_read  (data_mem_read),
        .data_mem_write (data_mem_write),
        .advance        (advance),
        .inst_rdata_q   (inst_rdata_q),
        .data_rdata_q   (data_rdata_q),
        .inst_stall_cnt (inst_stall_cnt),
        .data_stall_cnt (data_stall_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge; responses default to idle each cycle.
    task automatic tick();
        @(posedge clk);
        #1;
        inst_mem_resp = 1'b0;
        data_mem_resp = 1'b0;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".iread"}, inst_mem_read, 1'b0);
        chk({tag, ".dread"}, data_mem_read, 1'b0);
        chk({tag, ".dwrite"}, data_mem_write, 1'b0);
    endtask

    initial begin
        rst = 1'b0;
        need_data_read = 1'b0;
        need_data_write = 1'b0;
        stall_req = 1'b0;
        inst_mem_resp = 1'b0;
        inst_mem_rdata = '0;
        data_mem_resp = 1'b0;
        data_mem_rdata = '0;

        // Reset state, with a pending need that must stay masked.
        tick();
        need_data_read = 1'b1;
        tick();
        #1;
        chk_idle("rst");
        chk("rst.adv", advance, 1'b0);
        chk("rst.iq", inst_rdata_q, 32'h0);
        chk("rst.dq", data_rdata_q, 32'h0);
        chk("rst.icnt", inst_stall_cnt, '0);
        chk("rst.dcnt", data_stall_cnt, '0);
        rst = 1'b1;

        // Same-cycle responses: step cycle 0 is the release cycle.
        #1;
        chk("a0.iread", inst_mem_read, 1'b1);
        chk("a0.dread", data_mem_read, 1'b1);
        chk("a0.dwrite", data_mem_write, 1'b0);
        tick();
        inst_mem_resp = 1'b1; inst_mem_rdata = 32'h0000_0013;
        data_mem_resp = 1'b1; data_mem_rdata = 32'hDEAD_BEEF;
        #1;
        chk("a1.adv", advance, 1'b0);
        tick();
        #1;
        chk("a2.adv", advance, 1'b1);
        chk_idle("a2");
        chk("a2.iq", inst_rdata_q, 32'h0000_0013);
        chk("a2.dq", data_rdata_q, 32'hDEAD_BEEF);

        // Split responses: inst in cycle 1, data in cycle 4.
        tick();
        #1;
        chk("b0.adv", advance, 1'b0);
        chk("b0.iread", inst_mem_read, 1'b1);
        tick();
        inst_mem_resp = 1'b1; inst_mem_rdata = 32'h0010_0093;
        #1;
        chk("b1.dread", data_mem_read, 1'b1);
        tick();
        #1;
        chk("b2.iread", inst_mem_read, 1'b0);
        chk("b2.dread", data_mem_read, 1'b1);
        tick();
        #1;
        chk("b3.dread", data_mem_read, 1'b1);
        chk("b3.adv", advance, 1'b0);
        tick();
        data_mem_resp = 1'b1; data_mem_rdata = 32'h1234_5678;
        #1;
        chk("b4.dread", data_mem_read, 1'b1);
        chk("b4.adv", advance, 1'b0);
        tick();
        #1;
        chk("b5.adv", advance, 1'b1);
        chk("b5.iq", inst_rdata_q, 32'h0010_0093);
        chk("b5.dq", data_rdata_q, 32'h1234_5678);

        // No data need: inst resp in cycle 3, advance in cycle 4.
        tick();
        need_data_read = 1'b0;
        #1;
        chk("c0.adv", advance, 1'b0);
        chk("c0.iread", inst_mem_read, 1'b1);
        for (int i = 0; i < 3; i++) begin
            chk("c.dread", data_mem_read, 1'b0);
            chk("c.dwrite", data_mem_write, 1'b0);
            chk("c.adv", advance, 1'b0);
            tick();
            #1;
        end
        inst_mem_resp = 1'b1; inst_mem_rdata = 32'h0000_0033;
        #1;
        chk("c3.dread", data_mem_read, 1'b0);
        tick();
        #1;
        chk("c4.adv", advance, 1'b1);
        chk("c4.iq", inst_rdata_q, 32'h0000_0033);
        chk("c4.dq", data_rdata_q, 32'h1234_5678);

        // Store wins over load; stall holds the step until cycle 5.
        tick();
        need_data_write = 1'b1; need_data_read = 1'b1; stall_req = 1'b1;
        #1;
        chk("d0.dwrite", data_mem_write, 1'b1);
        chk("d0.dread", data_mem_read, 1'b0);
        tick();
        inst_mem_resp = 1'b1; inst_mem_rdata = 32'h0000_0073;
        data_mem_resp = 1'b1; data_mem_rdata = 32'hBADC_0FFE;
        #1;
        chk("d1.adv", advance, 1'b0);
        for (int i = 2; i < 5; i++) begin
            tick();
            #1;
            chk_idle("d.hold");
            chk("d.hold.adv", advance, 1'b0);
        end
        tick();
        stall_req = 1'b0;
        #1;
        chk("d5.adv", advance, 1'b0);
        chk_idle("d5");
        tick();
        #1;
        chk("d6.adv", advance, 1'b1);
        chk("d6.iq", inst_rdata_q, 32'h0000_0073);
        chk("d6.dq", data_rdata_q, 32'h1234_5678);

        // Reset mid-wait with a load outstanding and i_done already set.
        tick();
        need_data_write = 1'b0; need_data_read = 1'b1;
        #1;
        chk("e0.dread", data_mem_read, 1'b1);
        tick();
        inst_mem_resp = 1'b1; inst_mem_rdata = 32'h0000_0093;
        tick();
        #1;
        chk("e2.iread", inst_mem_read, 1'b0);
        chk("e2.dread", data_mem_read, 1'b1);
        rst = 1'b0;
        #1;
        chk_idle("e2.rst");
        chk("e2.rst.adv", advance, 1'b0);
        tick();
        #1;
        chk_idle("e3.rst");
        chk("e3.iq", inst_rdata_q, 32'h0);
        chk("e3.dq", data_rdata_q, 32'h0);
        rst = 1'b1;
        #1;
        chk("e3.iread", inst_mem_read, 1'b1);
        chk("e3.dread", data_mem_read, 1'b1);

        // Stall counters: data resp 1 cycle after request, inst resp 3 cycles after.
        chk("f0.icnt", inst_stall_cnt, '0);
        tick();
        data_mem_resp = 1'b1; data_mem_rdata = 32'hCAFE_F00D;
        tick();
        tick();
        inst_mem_resp = 1'b1; inst_mem_rdata = 32'h0000_00B3;
        tick();
        #1;
        chk("f4.adv", advance, 1'b1);
        chk("f4.dq", data_rdata_q, 32'hCAFE_F00D);
        chk("f4.icnt", inst_stall_cnt, EXP_I3);
        chk("f4.dcnt", data_stall_cnt, EXP_D1);

        // Long inst wait: 5 more stall cycles, then enough to saturate.
        tick();
        need_data_read = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        #1;
        chk("g.icnt8", inst_stall_cnt, EXP_I8);
        for (int i = 0; i < 15; i++) tick();
        #1;
        chk("g.icnt.sat", inst_stall_cnt, EXP_SAT);
        chk("g.dcnt", data_stall_cnt, EXP_D1);
        inst_mem_resp = 1'b1; inst_mem_rdata = 32'h0000_0013;
        tick();
        #1;
        chk("g.adv", advance, 1'b1);
        tick();
        tick();
        #1;
        chk("g.icnt.hold", inst_stall_cnt, EXP_SAT);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
